// File: rtl/mac_result_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_result_drain_if
// Description : Beat input, flag control and FIFO drain handshake bundle for
//               mac_result_drain.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_result_drain_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                    i_res_valid;
    logic                    i_res_last;
    logic signed [18:0]      i_res;
    logic [3:0]              i_shift;
    logic                    i_clr_flags;
    logic                    o_valid;
    logic                    i_ready;
    logic signed [7:0]       o_data;
    logic [CNT_W-1:0]        o_count;
    logic                    o_ovf;
    logic                    o_acc_sat;

    modport master (
        output i_res_valid, i_res_last, i_res, i_shift, i_clr_flags, i_ready,
        input  o_valid, o_data, o_count, o_ovf, o_acc_sat
    );

    modport slave (
        input  i_res_valid, i_res_last, i_res, i_shift, i_clr_flags, i_ready,
        output o_valid, o_data, o_count, o_ovf, o_acc_sat
    );
endinterface
`default_nettype wire

// File: rtl/mac_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : mac_result_drain
// Description : Saturating dot-product accumulator with rounding int8
//               requantisation feeding a small output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_result_drain #(
    parameter int ACC_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input wire logic          i_clk,
    input wire logic          i_rst,
    mac_result_drain_if.slave bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic signed [ACC_W:0]   c_ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   c_ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   c_Q_MAX   = {{(ACC_W-7){1'b0}}, 8'h7F};
    localparam logic signed [ACC_W:0]   c_Q_MIN   = {{(ACC_W-7){1'b1}}, 8'h80};
    localparam logic [c_CNT_W-1:0]      c_FULL    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]      c_ONE     = c_CNT_W'(1);

    logic signed [ACC_W-1:0] r_acc;
    logic [7:0]              r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;
    logic [7:0]              r_data;
    logic                    r_ovf;
    logic                    r_acc_sat;

    logic signed [ACC_W:0]   w_sum;
    logic                    w_clamp;
    logic signed [ACC_W:0]   w_sat;
    logic [ACC_W:0]          w_round;
    logic signed [ACC_W:0]   w_biased;
    logic signed [ACC_W:0]   w_rq;
    logic [7:0]              w_q;
    logic                    w_push_req;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_push;
    logic                    w_drop;
    logic [c_PTR_W-1:0]      w_rd_next;

    // Accumulate in one extra bit so overflow is visible as a sign disagreement.
    always_comb begin
        w_sum   = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-18){bus.i_res[18]}}, bus.i_res};
        w_clamp = (w_sum[ACC_W] != w_sum[ACC_W-1]);
        w_sat   = w_sum;
        if (w_clamp) begin
            w_sat = w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX;
        end
    end

    // Round half toward +inf, arithmetic shift, then clamp into int8.
    always_comb begin
        w_round  = '0;
        if (bus.i_shift != 4'd0) begin
            w_round = (ACC_W+1)'(1) << (bus.i_shift - 4'd1);
        end
        w_biased = w_sat + w_round;
        w_rq     = w_biased >>> bus.i_shift;
        w_q      = w_rq[7:0];
        if (w_rq > c_Q_MAX) begin
            w_q = 8'h7F;
        end else if (w_rq < c_Q_MIN) begin
            w_q = 8'h80;
        end
    end

    always_comb begin
        w_push_req = bus.i_res_valid & bus.i_res_last;
        w_pop      = (r_count != '0) & bus.i_ready;
        w_full     = (r_count == c_FULL);
        w_push     = w_push_req & (~w_full | w_pop);
        w_drop     = w_push_req & w_full & ~w_pop;
        w_rd_next  = r_rd_ptr + c_PTR_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc     <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_data    <= '0;
            r_ovf     <= 1'b0;
            r_acc_sat <= 1'b0;
        end else begin
            if (bus.i_res_valid) begin
                r_acc <= bus.i_res_last ? '0 : w_sat[ACC_W-1:0];
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
            // Head register keeps o_data stable (and holding) when the FIFO empties.
            if (w_pop) begin
                if (r_count > c_ONE) begin
                    r_data <= r_mem[w_rd_next];
                end else if (w_push) begin
                    r_data <= w_q;
                end
            end else if (w_push && (r_count == '0)) begin
                r_data <= w_q;
            end
            r_ovf     <= (r_ovf & ~bus.i_clr_flags) | w_drop;
            r_acc_sat <= (r_acc_sat & ~bus.i_clr_flags) | (bus.i_res_valid & w_clamp);
        end
    end

    assign bus.o_valid   = (r_count != '0);
    assign bus.o_data    = r_data;
    assign bus.o_count   = r_count;
    assign bus.o_ovf     = r_ovf;
    assign bus.o_acc_sat = r_acc_sat;
endmodule
`default_nettype wire

// File: tb/tb_mac_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_result_drain
// Description : Directed scoreboard bench for mac_result_drain (ACC_W=20).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_result_drain;
    localparam int ACC_W      = 20;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_result_drain_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    mac_result_drain #(
        .ACC_W      (ACC_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int                n_cmp = 0;
    int                n_err = 0;
    logic signed [7:0] q [$];
    logic signed [7:0] last_pop;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_res_valid = 1'b0;
        bus.i_res_last  = 1'b0;
        bus.i_res       = '0;
        bus.i_shift     = '0;
        bus.i_clr_flags = 1'b0;
        bus.i_ready     = 1'b0;
    endtask

    task automatic beat(input int v, input bit last, input int sh);
        bus.i_res_valid = 1'b1;
        bus.i_res_last  = last;
        bus.i_res       = 19'(v);
        bus.i_shift     = 4'(sh);
        step();
        bus.i_res_valid = 1'b0;
        bus.i_res_last  = 1'b0;
    endtask

    // Single-beat result with the consumer stalled; a full FIFO drops it.
    task automatic result(input int v, input int sh, input int exp);
        beat(v, 1'b1, sh);
        if (q.size() < FIFO_DEPTH) q.push_back(8'(exp));
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) begin
            check({tag, "_valid"}, bus.o_valid, 1);
            last_pop = q.pop_front();
            check({tag, "_data"}, bus.o_data, last_pop);
            bus.i_ready = 1'b1;
            step();
            bus.i_ready = 1'b0;
        end
        check({tag, "_empty"}, bus.o_valid, 0);
        check({tag, "_count0"}, bus.o_count, 0);
        check({tag, "_hold"}, bus.o_data, last_pop);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", bus.o_valid, 0);
        check("rst_count", bus.o_count, 0);
        check("rst_data", bus.o_data, 0);
        check("rst_ovf", bus.o_ovf, 0);
        check("rst_sat", bus.o_acc_sat, 0);

        // 100 + 200 - 50 = 250 saturates to 127 at shift 0
        beat(100, 1'b0, 0);
        beat(200, 1'b0, 0);
        check("mid_valid", bus.o_valid, 0);
        beat(-50, 1'b1, 0);
        q.push_back(8'sd127);
        check("r033_lat", bus.o_valid, 1);
        check("r033_sat", bus.o_acc_sat, 0);
        drain("r033");

        result(40, 4, 3);
        result(-40, 4, -2);
        result(-200, 0, -128);
        check("r034_count", bus.o_count, 3);
        drain("r034");

        bus.i_ready = 1'b1;
        step();
        step();
        bus.i_ready = 1'b0;
        check("empty_rdy_count", bus.o_count, 0);
        check("empty_rdy_hold", bus.o_data, -128);

        for (int i = 1; i <= 5; i++) result(i, 0, i);
        check("r035_count", bus.o_count, 4);
        check("r035_ovf", bus.o_ovf, 1);
        check("r035_head", bus.o_data, 1);
        bus.i_clr_flags = 1'b1;
        step();
        bus.i_clr_flags = 1'b0;
        check("r035_clr", bus.o_ovf, 0);
        drain("r035");

        // Full FIFO: push and pop in the same cycle
        for (int i = 1; i <= 4; i++) result(i, 0, i);
        check("r036_full", bus.o_count, 4);
        check("r036_head", bus.o_data, q[0]);
        void'(q.pop_front());
        q.push_back(8'sd9);
        bus.i_ready = 1'b1;
        beat(9, 1'b1, 0);
        bus.i_ready = 1'b0;
        check("r036_count", bus.o_count, 4);
        check("r036_ovf", bus.o_ovf, 0);
        drain("r036");

        // Positive clamp at 2^19-1; flag set coincides with clear and wins
        for (int i = 0; i < 3; i++) beat(131072, 1'b0, 15);
        check("r037_nosat", bus.o_acc_sat, 0);
        bus.i_clr_flags = 1'b1;
        beat(131072, 1'b1, 15);
        bus.i_clr_flags = 1'b0;
        q.push_back(8'sd16);
        check("r037_sat", bus.o_acc_sat, 1);
        drain("r037");
        bus.i_clr_flags = 1'b1;
        step();
        bus.i_clr_flags = 1'b0;
        check("r037_clr", bus.o_acc_sat, 0);

        // Negative clamp: exactly -2^19 is legal, one more step clamps
        beat(-262144, 1'b0, 0);
        beat(-262144, 1'b0, 0);
        check("neg_edge_nosat", bus.o_acc_sat, 0);
        beat(-1, 1'b1, 0);
        q.push_back(-8'sd128);
        check("neg_sat", bus.o_acc_sat, 1);
        drain("neg");

        // Reset mid-accumulation with a last beat present: reset wins
        beat(500, 1'b0, 0);
        beat(500, 1'b0, 0);
        rst             = 1'b1;
        bus.i_res_valid = 1'b1;
        bus.i_res_last  = 1'b1;
        bus.i_res       = 19'sd5;
        step();
        rst = 1'b0;
        idle();
        check("r038_count", bus.o_count, 0);
        check("r038_valid", bus.o_valid, 0);
        check("r038_data", bus.o_data, 0);
        check("r038_sat", bus.o_acc_sat, 0);
        beat(7, 1'b1, 0);
        q.push_back(8'sd7);
        drain("r038");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mac_result_drain.md
MAC_RESULT_DRAIN -- requirements
Module: mac_result_drain

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter ACC_W, default 32, accumulator width in bits (legal range 20..40).
REQ-003 Parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, at least 2).
REQ-004 i_clk  input  1  rising-edge clock.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_res_valid  input  1  i_res carries a valid dot-product beat this cycle.
REQ-007 i_res_last  input  1  beat is the final partial sum of the current output; ignored when i_res_valid=0.
REQ-008 i_res  input  19  signed dot-product beat.
REQ-009 i_shift  input  4  requantisation right-shift (0..15); sampled only on a valid last beat.
REQ-010 i_clr_flags  input  1  clears the sticky flags.
REQ-011 o_valid  output  1  FIFO non-empty; o_data valid.
REQ-012 i_ready  input  1  consumer accepts o_data.
REQ-013 o_data  output  8  signed int8 result at the FIFO head.
REQ-014 o_count  output  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-015 o_ovf  output  1  sticky: a result was dropped because the FIFO was full.
REQ-016 o_acc_sat  output  1  sticky: the accumulator saturated.

Function
REQ-017 Valid beat with last=0: acc <= sat_ACC_W(acc + sext(i_res)); sum formed in ACC_W+1 bits; clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-018 Valid beat with last=1: final = sat_ACC_W(acc + sext(i_res)); acc <= 0 in the same cycle; requant(final) is offered for push.
REQ-019 A clamp in REQ-017 or REQ-018 SHALL set o_acc_sat.
REQ-020 requant(x): r = (x + (i_shift>0 ? 2^(i_shift-1) : 0)) >>> i_shift, computed in ACC_W+1 bits (round half toward +inf); then saturate to [-128, 127].
REQ-021 A single-beat output (valid, last=1, acc=0) is legal and equals requant(i_res).
REQ-022 Push latency: a result pushed at edge N is visible on o_data with o_valid=1 after edge N when the FIFO was empty; no combinational path from i_res to o_data.
REQ-023 A pop occurs when o_valid=1 and i_ready=1; o_data advances to the next entry in FIFO order after that edge.
REQ-024 FIFO full with no pop in the cycle: offered result dropped, o_ovf set, contents and o_count unchanged.
REQ-025 FIFO full with a pop in the same cycle: push accepted, o_count unchanged.
REQ-026 FIFO empty: i_ready ignored, o_count never goes negative; o_data holds its last value.
REQ-027 Read/write pointers wrap modulo FIFO_DEPTH with no loss or duplication.
REQ-028 i_clr_flags clears o_ovf and o_acc_sat; a setting event in the same cycle wins (flag reads 1).
REQ-029 i_res_last, i_shift and i_res are don't-care when i_res_valid=0; acc holds.

Reset
REQ-030 On i_rst=1 at an edge: acc=0, FIFO emptied, o_valid=0, o_count=0, o_data=0, o_ovf=0, o_acc_sat=0.
REQ-031 Reset mid-accumulation discards the partial sum; the first valid beat after reset starts a new output from acc=0.
REQ-032 i_rst takes priority over all other inputs in the same cycle.

Verification
REQ-033 Beats 100, 200, -50(last), shift 0 -> one push of 127 (250 saturated); o_valid=1 the cycle after the last beat; o_acc_sat=0.
REQ-034 Single last beat 40, shift 4 -> o_data=3; single last beat -40, shift 4 -> o_data=-2; single last beat -200, shift 0 -> o_data=-128.
REQ-035 i_ready=0, five single-beat results 1..5, FIFO_DEPTH=4 -> o_count=4, o_ovf=1, then drain yields 1,2,3,4 and o_valid=0.
REQ-036 FIFO full, last beat 9 together with o_valid=1 and i_ready=1 -> head popped, 9 accepted at tail, o_count stays 4, o_ovf stays 0.
REQ-037 ACC_W=20, four beats of 131072 (last on the fourth), shift 15 -> acc clamps at 524287, o_acc_sat=1, o_data=16; i_clr_flags then clears o_acc_sat.
REQ-038 Beats 500, 500, then i_rst=1 for one cycle, then last beat 7, shift 0 -> o_data=7; no stale partial sum and no result pushed during reset.
